// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, RAM and debug signals shared by the arbiter and its environment.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [3:0]        wait_cnt;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output wait_cnt
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  wait_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port fixed-priority arbiter for a single-port synchronous RAM, with port-1
// starvation forcing and owner-tagged routing of the 1-cycle-late read data.
module mem_port_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_port_arbiter_if.slave       bus
);
  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic              w_force1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  logic [3:0]        r_wait_cnt;
  logic              r_tag_vld;
  logic              r_tag_port;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  // Grant decision and RAM request mux
  always_comb begin
    w_force1    = (r_wait_cnt >= LP_MAX_WAIT);
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if (bus.req1 && (w_force1 || !bus.req0)) begin
      w_gnt1      = 1'b1;
      w_mem_we    = bus.we1;
      w_mem_addr  = bus.addr1;
      w_mem_wdata = bus.wdata1;
    end else if (bus.req0) begin
      w_gnt0      = 1'b1;
      w_mem_we    = bus.we0;
      w_mem_addr  = bus.addr0;
      w_mem_wdata = bus.wdata0;
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // Starvation counter, read-owner tag and per-port read data holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
      r_tag_vld  <= 1'b0;
      r_tag_port <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      if (w_gnt1 || !bus.req1) begin
        r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt != 4'd15) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
      r_tag_vld  <= (w_gnt0 || w_gnt1) && !w_mem_we;
      r_tag_port <= w_gnt1;
      if (r_tag_vld && !r_tag_port) begin
        r_rdata0 <= bus.mem_rdata;
      end else begin
        r_rdata0 <= r_rdata0;
      end
      if (r_tag_vld && r_tag_port) begin
        r_rdata1 <= bus.mem_rdata;
      end else begin
        r_rdata1 <= r_rdata1;
      end
    end
  end

  // The returning word is only present on mem_rdata during the valid cycle,
  // so it is passed through then and held by the port's register afterwards.
  assign bus.rvalid0   = r_tag_vld && !r_tag_port;
  assign bus.rvalid1   = r_tag_vld && r_tag_port;
  assign bus.rdata0    = bus.rvalid0 ? bus.mem_rdata : r_rdata0;
  assign bus.rdata1    = bus.rvalid1 ? bus.mem_rdata : r_rdata1;
  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.mem_en    = w_gnt0 || w_gnt1;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.wait_cnt  = r_wait_cnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [DATA_W-1:0] ram [0:255];
  logic [DATA_W-1:0] ram_q;

  mem_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM model
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            ram_q <= ram[bus.mem_addr[7:0]];
    end
  end
  assign bus.mem_rdata = ram_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) ram[i] = 64'd0;
    ram[1] = 64'hAAAA_AAAA_AAAA_AAAA;
    ram[2] = 64'hBBBB_BBBB_BBBB_BBBB;
    ram_q  = 64'd0;
    rst = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0000; bus.wdata0 = 64'd0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0000; bus.wdata1 = 64'd0;

    // Reset state: no grants while rst even with both requests up
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt0", 64'(bus.gnt0), 64'd0);
    chk("rst_gnt1", 64'(bus.gnt1), 64'd0);
    chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
    chk("rst_wait", 64'(bus.wait_cnt), 64'd0);
    chk("rst_rvalid", 64'({bus.rvalid0, bus.rvalid1}), 64'd0);
    chk("rst_rdata0", bus.rdata0, 64'd0);
    chk("rst_rdata1", bus.rdata1, 64'd0);

    // Port-0 write then read of 0x0010
    @(negedge clk);
    rst = 1'b0; bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0010; bus.wdata0 = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("p0w_gnt0", 64'(bus.gnt0), 64'd1);
    chk("p0w_gnt1", 64'(bus.gnt1), 64'd0);
    chk("p0w_mem_we", 64'(bus.mem_we), 64'd1);
    chk("p0w_mem_addr", 64'(bus.mem_addr), 64'h10);
    chk("p0w_mem_wdata", bus.mem_wdata, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    bus.we0 = 1'b0;
    #1;
    chk("p0r_gnt0", 64'(bus.gnt0), 64'd1);
    chk("p0r_mem_we", 64'(bus.mem_we), 64'd0);
    chk("p0w_no_rvalid", 64'({bus.rvalid0, bus.rvalid1}), 64'd0);
    @(negedge clk);
    bus.req0 = 1'b0;
    #1;
    chk("p0r_rvalid0", 64'(bus.rvalid0), 64'd1);
    chk("p0r_rdata0", bus.rdata0, 64'h0123_4567_89AB_CDEF);
    chk("p0r_rvalid1", 64'(bus.rvalid1), 64'd0);
    chk("idle_mem_en", 64'(bus.mem_en), 64'd0);
    chk("idle_mem_addr", 64'(bus.mem_addr), 64'd0);
    @(negedge clk);
    #1;
    chk("p0r_pulse", 64'(bus.rvalid0), 64'd0);
    chk("p0r_hold", bus.rdata0, 64'h0123_4567_89AB_CDEF);

    // Back-to-back reads on different ports
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0001;
    #1;
    chk("b2b_gnt0", 64'(bus.gnt0), 64'd1);
    @(negedge clk);
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0002;
    #1;
    chk("b2b_gnt1", 64'(bus.gnt1), 64'd1);
    chk("b2b_rvalid0", 64'(bus.rvalid0), 64'd1);
    chk("b2b_rdata0", bus.rdata0, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("b2b_rvalid1_n1", 64'(bus.rvalid1), 64'd0);
    @(negedge clk);
    bus.req1 = 1'b0;
    #1;
    chk("b2b_rvalid1", 64'(bus.rvalid1), 64'd1);
    chk("b2b_rdata1", bus.rdata1, 64'hBBBB_BBBB_BBBB_BBBB);
    chk("b2b_rvalid0_n2", 64'(bus.rvalid0), 64'd0);
    chk("b2b_rdata0_hold", bus.rdata0, 64'hAAAA_AAAA_AAAA_AAAA);

    // Contention with MAX_WAIT=4: four port-0 wins, then forced port-1 grant
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0003;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0004;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_gnt0", 64'(bus.gnt0), 64'd1);
      chk("cont_gnt1", 64'(bus.gnt1), 64'd0);
      chk("cont_wait", 64'(bus.wait_cnt), 64'(k));
      @(negedge clk);
    end
    #1;
    chk("cont_wait4", 64'(bus.wait_cnt), 64'd4);
    chk("cont_force_gnt1", 64'(bus.gnt1), 64'd1);
    chk("cont_force_gnt0", 64'(bus.gnt0), 64'd0);
    chk("cont_force_addr", 64'(bus.mem_addr), 64'h4);
    @(negedge clk);
    bus.req1 = 1'b0;
    #1;
    chk("cont_wait_clr", 64'(bus.wait_cnt), 64'd0);
    chk("cont_gnt0_resume", 64'(bus.gnt0), 64'd1);

    // Port-1 idle: counter stays 0, RAM bus follows port 0
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.we0 = 1'b1; bus.addr0 = 16'h0050 + 16'(k); bus.wdata0 = 64'hC0DE_0000_0000_0000 + 64'(k);
      #1;
      chk("idle1_wait", 64'(bus.wait_cnt), 64'd0);
      chk("idle1_mem_we", 64'(bus.mem_we), 64'd1);
      chk("idle1_mem_addr", 64'(bus.mem_addr), 64'h50 + 64'(k));
      chk("idle1_mem_wdata", bus.mem_wdata, 64'hC0DE_0000_0000_0000 + 64'(k));
    end

    // Reset while a port-1 read is in flight
    @(negedge clk);
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0001;
    #1;
    chk("rmid_gnt1", 64'(bus.gnt1), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmid_no_gnt", 64'({bus.gnt0, bus.gnt1, bus.mem_en}), 64'd0);
    @(negedge clk);
    #1;
    chk("rmid_rvalid1", 64'(bus.rvalid1), 64'd0);
    chk("rmid_rdata1", bus.rdata1, 64'd0);
    chk("rmid_wait", 64'(bus.wait_cnt), 64'd0);
    chk("rmid_gnt1_rst", 64'(bus.gnt1), 64'd0);
    @(negedge clk);
    rst = 1'b0; bus.req1 = 1'b0;

    // Port-1 write yields no return, then read it back
    @(negedge clk);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h00FF; bus.wdata1 = 64'h5A5A_0F0F_1234_8765;
    #1;
    chk("w1_gnt1", 64'(bus.gnt1), 64'd1);
    chk("w1_mem_we", 64'(bus.mem_we), 64'd1);
    chk("w1_mem_addr", 64'(bus.mem_addr), 64'hFF);
    @(negedge clk);
    bus.req1 = 1'b0;
    #1;
    chk("w1_no_rv_1", 64'({bus.rvalid0, bus.rvalid1}), 64'd0);
    @(negedge clk);
    #1;
    chk("w1_no_rv_2", 64'({bus.rvalid0, bus.rvalid1}), 64'd0);
    bus.req1 = 1'b1; bus.we1 = 1'b0;
    @(negedge clk);
    bus.req1 = 1'b0;
    #1;
    chk("w1_rb_rvalid1", 64'(bus.rvalid1), 64'd1);
    chk("w1_rb_rdata1", bus.rdata1, 64'h5A5A_0F0F_1234_8765);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
